// File: rtl/cg_mem_arbiter.sv
// cg_mem_arbiter: merges NUM_CH requesters onto one memory port.
// Ports: s_* per-channel AR/R/W, m_* downstream AR/R/W, rd_outstanding, err_unexp_r.
module cg_mem_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  s_arvalid,
  output logic [NUM_CH-1:0]                  s_arready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]       s_araddr,
  output logic [NUM_CH-1:0]                  s_rvalid,
  input  logic [NUM_CH-1:0]                  s_rready,
  output logic [NUM_CH*DATA_WIDTH-1:0]       s_rdata,
  input  logic [NUM_CH-1:0]                  s_wvalid,
  output logic [NUM_CH-1:0]                  s_wready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]       s_waddr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       s_wdata,
  input  logic [NUM_CH*STRB_WIDTH-1:0]       s_wstrb,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  output logic [ADDR_WIDTH-1:0]              m_araddr,
  input  logic                               m_rvalid,
  output logic                               m_rready,
  input  logic [DATA_WIDTH-1:0]              m_rdata,
  output logic                               m_wvalid,
  input  logic                               m_wready,
  output logic [ADDR_WIDTH-1:0]              m_waddr,
  output logic [DATA_WIDTH-1:0]              m_wdata,
  output logic [STRB_WIDTH-1:0]              m_wstrb,
  output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding,
  output logic                               err_unexp_r
);

  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int OW = PW + 1;
  localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  // first requester at or after ptr, wrapping
  function automatic logic [CW-1:0] rr_pick(
    input logic [NUM_CH-1:0] req,
    input logic [CW-1:0]     ptr
  );
    logic [CW-1:0] pick;
    logic          hit;
    int            j;
    pick = ptr;
    hit  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!hit && req[j]) begin
        hit  = 1'b1;
        pick = CW'(j);
      end
    end
    return pick;
  endfunction

  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] idx);
    return (idx == CW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // ---------------- read-ID FIFO ----------------
  logic [CW-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wp, r_rp;
  logic [OW-1:0] r_cnt;
  logic          w_empty, w_full, w_pop;
  logic [CW-1:0] w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == OW'(MAX_OUTSTANDING));
  assign w_head  = r_fifo[r_rp];
  assign w_pop   = m_rvalid && m_rready;

  // ---------------- AR stage ----------------
  logic [CW-1:0]         r_ar_ptr, w_ar_win;
  logic                  r_arvalid, w_ar_acc;
  logic [ADDR_WIDTH-1:0] r_araddr;

  assign w_ar_win = rr_pick(s_arvalid, r_ar_ptr);
  // full blocks acceptance even when a pop lands this cycle
  assign w_ar_acc = !rst && (!r_arvalid || m_arready)
                    && !w_full && (|s_arvalid);
  assign s_arready = w_ar_acc ? (ONE << w_ar_win) : '0;
  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_araddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_ar_ptr  <= '0;
    end else if (w_ar_acc) begin
      r_arvalid <= 1'b1;
      r_araddr  <= s_araddr[w_ar_win*ADDR_WIDTH +: ADDR_WIDTH];
      r_ar_ptr  <= rr_next(w_ar_win);
    end else if (m_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ar_acc) r_fifo[r_wp] <= w_ar_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_ar_acc) r_wp <= r_wp + 1'b1;
      if (w_pop)    r_rp <= r_rp + 1'b1;
      if (w_ar_acc && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_ar_acc && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign rd_outstanding = r_cnt;

  // ---------------- R routing ----------------
  assign m_rready = !rst && !w_empty && s_rready[w_head];
  assign s_rvalid = (!rst && !w_empty && m_rvalid) ? (ONE << w_head) : '0;
  assign s_rdata  = {NUM_CH{m_rdata}};

  always_ff @(posedge clk) begin
    if (rst)                      err_unexp_r <= 1'b0;
    else if (m_rvalid && w_empty) err_unexp_r <= 1'b1;
  end

  // ---------------- W stage ----------------
  logic [CW-1:0]         r_w_ptr, w_w_win;
  logic                  r_wvalid, w_w_acc;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  assign w_w_win  = rr_pick(s_wvalid, r_w_ptr);
  assign w_w_acc  = !rst && (!r_wvalid || m_wready) && (|s_wvalid);
  assign s_wready = w_w_acc ? (ONE << w_w_win) : '0;
  assign m_wvalid = r_wvalid;
  assign m_waddr  = r_waddr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wvalid <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_w_ptr  <= '0;
    end else if (w_w_acc) begin
      r_wvalid <= 1'b1;
      r_waddr  <= s_waddr[w_w_win*ADDR_WIDTH +: ADDR_WIDTH];
      r_wdata  <= s_wdata[w_w_win*DATA_WIDTH +: DATA_WIDTH];
      r_wstrb  <= s_wstrb[w_w_win*STRB_WIDTH +: STRB_WIDTH];
      r_w_ptr  <= rr_next(w_w_win);
    end else if (m_wready) begin
      r_wvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cg_mem_arbiter.sv
// tb_cg_mem_arbiter: directed vector bench for cg_mem_arbiter.
// Table rows drive one cycle each; write path uses a hand sequence.
module tb_cg_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic [3:0]   s_wvalid, s_wready;
  logic [127:0] s_araddr, s_rdata, s_waddr, s_wdata;
  logic [15:0]  s_wstrb;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;
  logic         m_wvalid, m_wready;
  logic [31:0]  m_araddr, m_rdata, m_waddr, m_wdata;
  logic [3:0]   m_wstrb;
  logic [2:0]   rd_outstanding;
  logic         err_unexp_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cg_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_waddr(s_waddr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .rd_outstanding(rd_outstanding), .err_unexp_r(err_unexp_r)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  arv;
    logic        marr;
    logic        mrv;
    logic [31:0] rdata;
    logic [3:0]  rrdy;
    logic        chk;
    logic [3:0]  e_arr;
    logic        e_marv;
    logic [31:0] e_addr;
    logic [3:0]  e_srv;
    logic        e_mrr;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] arv, input logic marr,
    input logic mrv, input logic [31:0] rd, input logic [3:0] rrdy,
    input logic chk, input logic [3:0] earr, input logic emarv,
    input logic [31:0] eaddr, input logic [3:0] esrv,
    input logic emrr, input logic [2:0] eout, input logic eerr
  );
    vec_t v;
    v.rst = r; v.arv = arv; v.marr = marr; v.mrv = mrv;
    v.rdata = rd; v.rrdy = rrdy; v.chk = chk; v.e_arr = earr;
    v.e_marv = emarv; v.e_addr = eaddr; v.e_srv = esrv;
    v.e_mrr = emrr; v.e_out = eout; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
    end
  endtask

  initial begin
    // channel read addresses: ch0 0x000, ch1 0x040, ch2 0x100, ch3 0x3C0
    s_araddr  = {32'h3C0, 32'h100, 32'h040, 32'h000};
    rst = 1'b1;
    s_arvalid = '0; s_rready = '0; s_wvalid = '0;
    s_waddr = '0; s_wdata = '0; s_wstrb = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_wready = 1'b0;

    // single read ch2
    tv.push_back(mk(0,4'b0100,1,0,0,4'hF, 1,4'b0100,0,0,4'b0000,0,0,0));
    tv.push_back(mk(0,4'b0000,1,0,0,4'hF, 1,4'b0000,1,32'h100,4'b0000,1,1,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hDEADBEEF,4'hF, 1,4'b0000,0,0,4'b0100,1,1,0));
    tv.push_back(mk(0,4'b0000,1,0,0,4'hF, 1,4'b0000,0,0,4'b0000,0,0,0));
    // unexpected response, then reset while a request is held
    tv.push_back(mk(0,4'b0000,1,1,32'h55,4'hF, 1,4'b0000,0,0,4'b0000,0,0,0));
    tv.push_back(mk(0,4'b0100,1,0,0,4'hF, 1,4'b0100,0,0,4'b0000,0,0,1));
    tv.push_back(mk(0,4'b0000,0,0,0,4'hF, 1,4'b0000,1,32'h100,4'b0000,1,1,1));
    tv.push_back(mk(1,4'b1111,1,0,0,4'hF, 0,0,0,0,0,0,0,0));
    // all channels requesting: 0,1,2,3,0 with responses draining
    tv.push_back(mk(0,4'b1111,1,0,0,4'hF, 1,4'b0001,0,0,4'b0000,0,0,0));
    tv.push_back(mk(0,4'b1111,1,1,32'hA0,4'hF, 1,4'b0010,1,32'h000,4'b0001,1,1,0));
    tv.push_back(mk(0,4'b1111,1,1,32'hA1,4'hF, 1,4'b0100,1,32'h040,4'b0010,1,1,0));
    tv.push_back(mk(0,4'b1111,1,1,32'hA2,4'hF, 1,4'b1000,1,32'h100,4'b0100,1,1,0));
    tv.push_back(mk(0,4'b1111,1,1,32'hA3,4'hF, 1,4'b0001,1,32'h3C0,4'b1000,1,1,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hA4,4'hF, 1,4'b0000,1,32'h000,4'b0001,1,1,0));
    // outstanding limit
    tv.push_back(mk(0,4'b1111,1,0,0,4'hF, 1,4'b0010,0,0,4'b0000,0,0,0));
    tv.push_back(mk(0,4'b1111,1,0,0,4'hF, 1,4'b0100,1,32'h040,4'b0000,1,1,0));
    tv.push_back(mk(0,4'b1111,1,0,0,4'hF, 1,4'b1000,1,32'h100,4'b0000,1,2,0));
    tv.push_back(mk(0,4'b1111,1,0,0,4'hF, 1,4'b0001,1,32'h3C0,4'b0000,1,3,0));
    tv.push_back(mk(0,4'b1111,1,0,0,4'hF, 1,4'b0000,1,32'h000,4'b0000,1,4,0));
    tv.push_back(mk(0,4'b1111,1,1,32'hB1,4'hF, 1,4'b0000,0,0,4'b0010,1,4,0));
    tv.push_back(mk(0,4'b1111,1,0,0,4'hF, 1,4'b0010,0,0,4'b0000,1,3,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hB2,4'hF, 1,4'b0000,1,32'h040,4'b0100,1,4,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hB3,4'hF, 1,4'b0000,0,0,4'b1000,1,3,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hB4,4'hF, 1,4'b0000,0,0,4'b0001,1,2,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hB5,4'hF, 1,4'b0000,0,0,4'b0010,1,1,0));
    // ch3 then ch1, ch1 stalls only while at head
    tv.push_back(mk(0,4'b1000,1,0,0,4'hF, 1,4'b1000,0,0,4'b0000,0,0,0));
    tv.push_back(mk(0,4'b0010,1,0,0,4'hF, 1,4'b0010,1,32'h3C0,4'b0000,1,1,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hAAAA0003,4'b1101, 1,4'b0000,1,32'h040,4'b1000,1,2,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hBBBB0001,4'b1101, 1,4'b0000,0,0,4'b0010,0,1,0));
    tv.push_back(mk(0,4'b0000,1,1,32'hBBBB0001,4'b1111, 1,4'b0000,0,0,4'b0010,1,1,0));
    tv.push_back(mk(0,4'b0000,1,0,0,4'hF, 1,4'b0000,0,0,4'b0000,0,0,0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_arready", -1, s_arready, 0);
    chk("rst_marvalid", -1, m_arvalid, 0);
    chk("rst_mwvalid", -1, m_wvalid, 0);
    chk("rst_srvalid", -1, s_rvalid, 0);
    chk("rst_mrready", -1, m_rready, 0);
    chk("rst_out", -1, rd_outstanding, 0);
    chk("rst_err", -1, err_unexp_r, 0);
    @(negedge clk);

    foreach (tv[i]) begin
      rst       = tv[i].rst;
      s_arvalid = tv[i].arv;
      m_arready = tv[i].marr;
      m_rvalid  = tv[i].mrv;
      m_rdata   = tv[i].rdata;
      s_rready  = tv[i].rrdy;
      #1;
      if (tv[i].chk) begin
        chk("arready", i, s_arready, tv[i].e_arr);
        chk("marvalid", i, m_arvalid, tv[i].e_marv);
        if (tv[i].e_marv) chk("maraddr", i, m_araddr, tv[i].e_addr);
        chk("srvalid", i, s_rvalid, tv[i].e_srv);
        chk("mrready", i, m_rready, tv[i].e_mrr);
        chk("outstanding", i, rd_outstanding, tv[i].e_out);
        chk("err", i, err_unexp_r, tv[i].e_err);
        chk("srdata", i, s_rdata, {4{tv[i].rdata}});
      end
      @(negedge clk);
    end
    rst = 1'b0; s_arvalid = '0; m_rvalid = 1'b0; s_rready = '0;

    // write from ch1 with downstream stalled three cycles
    s_wvalid = 4'b0010;
    s_waddr[32 +: 32] = 32'h2004;
    s_wdata[32 +: 32] = 32'hCAFEF00D;
    s_wstrb[4 +: 4]   = 4'b0011;
    m_wready = 1'b0;
    #1;
    chk("w_accept", 100, s_wready, 4'b0010);
    chk("w_idle", 100, m_wvalid, 0);
    @(negedge clk);
    s_waddr[32 +: 32] = 32'h2008;
    s_wdata[32 +: 32] = 32'h11112222;
    s_wstrb[4 +: 4]   = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("w_stall_rdy", 101 + k, s_wready, 0);
      chk("w_stall_vld", 101 + k, m_wvalid, 1);
      chk("w_stall_addr", 101 + k, m_waddr, 32'h2004);
      chk("w_stall_data", 101 + k, m_wdata, 32'hCAFEF00D);
      chk("w_stall_strb", 101 + k, m_wstrb, 4'b0011);
      @(negedge clk);
    end
    m_wready = 1'b1;
    #1;
    chk("w_drain_rdy", 104, s_wready, 4'b0010);
    chk("w_drain_data", 104, m_wdata, 32'hCAFEF00D);
    @(negedge clk);
    s_wvalid = '0;
    #1;
    chk("w2_vld", 105, m_wvalid, 1);
    chk("w2_addr", 105, m_waddr, 32'h2008);
    chk("w2_data", 105, m_wdata, 32'h11112222);
    chk("w2_strb", 105, m_wstrb, 4'b1111);
    @(negedge clk);
    #1;
    chk("w_empty", 106, m_wvalid, 0);
    @(negedge clk);
    // W pointer sits at ch2 after ch1 won
    s_wvalid = 4'b1111;
    s_waddr[64 +: 32] = 32'h3000;
    s_wdata[64 +: 32] = 32'h33334444;
    s_wstrb[8 +: 4]   = 4'b1000;
    #1;
    chk("w_rr", 107, s_wready, 4'b0100);
    @(negedge clk);
    s_wvalid = '0;
    #1;
    chk("w_rr_vld", 108, m_wvalid, 1);
    chk("w_rr_addr", 108, m_waddr, 32'h3000);
    chk("w_rr_strb", 108, m_wstrb, 4'b1000);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
